// File: rtl/mips_pkg.sv
// Shared encodings and types for the MIPS core front end.
package mips_pkg;
  localparam logic [1:0]  JMP_SEQ = 2'b00;
  localparam logic [1:0]  JMP_J   = 2'b01;
  localparam logic [1:0]  JMP_JR  = 2'b10;
  localparam logic [31:0] NOP_INSTR        = 32'h0;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

  typedef enum logic [1:0] {BOOT, REQ, SKID, DROP} fetch_state_e;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a NOP bubble, load captures, otherwise hold.
module if_id_reg
  import mips_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         flush,
  input  logic [W-1:0] instr_d,
  input  logic [W-1:0] pc4_d,
  output logic [W-1:0] instr,
  output logic [W-1:0] pc4,
  output logic         valid
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr <= W'(NOP_INSTR);
      pc4   <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= W'(NOP_INSTR);
      pc4   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_d;
      pc4   <= pc4_d;
      valid <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, req/ready imem handshake, one-entry skid buffer and IF/ID register.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_ready_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  stall_i,
  input  logic                  zero_i,
  input  logic                  branch_eq_i,
  input  logic                  branch_ne_i,
  input  logic [1:0]            jmp_ctl_i,
  input  logic [DATA_WIDTH-1:0] branch_target_i,
  input  logic [25:0]           jump_index_i,
  input  logic [DATA_WIDTH-1:0] jr_target_i,
  output logic [DATA_WIDTH-1:0] if_id_instr_o,
  output logic [DATA_WIDTH-1:0] if_id_pc4_o,
  output logic                  if_id_valid_o
);
  fetch_state_e          state;
  logic [DATA_WIDTH-1:0] pc_q, addr_q, skid_instr, skid_pc4;
  logic [DATA_WIDTH-1:0] target, ifid_instr_d, ifid_pc4_d;
  logic                  req_q, taken, redirect, load_new, load_skid, ifid_load, ifid_flush;

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;

  always_comb begin
    taken    = (branch_eq_i & zero_i) | (branch_ne_i & ~zero_i) |
               (jmp_ctl_i == JMP_J) | (jmp_ctl_i == JMP_JR);
    redirect = if_id_valid_o & ~stall_i & taken;
    if (jmp_ctl_i == JMP_JR)     target = jr_target_i;
    else if (jmp_ctl_i == JMP_J) target = {if_id_pc4_o[DATA_WIDTH-1 -: 4], jump_index_i, 2'b00};
    else                         target = branch_target_i;
    // An empty IF/ID may be filled even under stall; only a live instruction forces the skid.
    load_new     = (state == REQ) & imem_ready_i & ~redirect & (~stall_i | ~if_id_valid_o);
    load_skid    = (state == SKID) & ~stall_i & ~redirect;
    ifid_load    = load_new | load_skid;
    ifid_flush   = ~stall_i & ~ifid_load;
    ifid_instr_d = load_skid ? skid_instr : imem_rdata_i;
    ifid_pc4_d   = load_skid ? skid_pc4 : addr_q + DATA_WIDTH'(4);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= BOOT;
      pc_q       <= DATA_WIDTH'(RESET_PC);
      addr_q     <= DATA_WIDTH'(RESET_PC);
      req_q      <= 1'b0;
      skid_instr <= '0;
      skid_pc4   <= '0;
    end else begin
      case (state)
        BOOT: begin
          state  <= REQ;
          req_q  <= 1'b1;
          addr_q <= pc_q;
        end
        REQ: begin
          if (redirect) begin
            pc_q <= target;
            // Without ready the request must complete at its old address before retargeting.
            if (imem_ready_i) addr_q <= target;
            else              state  <= DROP;
          end else if (imem_ready_i) begin
            pc_q <= pc_q + DATA_WIDTH'(4);
            if (stall_i && if_id_valid_o) begin
              skid_instr <= imem_rdata_i;
              skid_pc4   <= addr_q + DATA_WIDTH'(4);
              req_q      <= 1'b0;
              state      <= SKID;
            end else begin
              addr_q <= pc_q + DATA_WIDTH'(4);
            end
          end
        end
        SKID: begin
          if (!stall_i) begin
            state <= REQ;
            req_q <= 1'b1;
            if (redirect) begin
              pc_q   <= target;
              addr_q <= target;
            end else begin
              addr_q <= pc_q;
            end
          end
        end
        DROP: begin
          if (imem_ready_i) begin
            state  <= REQ;
            addr_q <= pc_q;
          end
        end
        default: begin
          state <= BOOT;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg #(.W(DATA_WIDTH)) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .load    (ifid_load),
    .flush   (ifid_flush),
    .instr_d (ifid_instr_d),
    .pc4_d   (ifid_pc4_d),
    .instr   (if_id_instr_o),
    .pc4     (if_id_pc4_o),
    .valid   (if_id_valid_o)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// Scenario bench for fetch_stage: imem model plus scoreboard of instructions consumed by decode.
module tb_fetch_stage;
  logic        clk = 1'b0, reset = 1'b0, ready = 1'b0, stall = 1'b0;
  logic        zero = 1'b0, beq = 1'b0, bne = 1'b0, ovr_en = 1'b0;
  logic [1:0]  jmp = 2'b00;
  logic [31:0] btgt = '0, jrtgt = '0, ovr_val = '0;
  logic [25:0] jidx = '0;
  logic        req, id_valid;
  logic [31:0] addr, rdata, id_instr, id_pc4;

  typedef logic [63:0] ent_t;
  ent_t exp_q[$], obs_q[$];
  ent_t e_ent, o_ent;
  int   pass_cnt = 0, chk_cnt = 0;

  function automatic logic [31:0] m(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  assign rdata = ovr_en ? ovr_val : m(addr);
  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .imem_req_o(req), .imem_addr_o(addr),
    .imem_ready_i(ready), .imem_rdata_i(rdata), .stall_i(stall), .zero_i(zero),
    .branch_eq_i(beq), .branch_ne_i(bne), .jmp_ctl_i(jmp), .branch_target_i(btgt),
    .jump_index_i(jidx), .jr_target_i(jrtgt), .if_id_instr_o(id_instr),
    .if_id_pc4_o(id_pc4), .if_id_valid_o(id_valid)
  );

  // Advance one cycle; an instruction valid and unstalled before the edge is consumed by decode.
  task automatic tick();
    if (id_valid && !stall) obs_q.push_back({id_instr, id_pc4});
    @(posedge clk); #1;
  endtask

  task automatic restart();
    reset = 1'b0; ready = 1'b1; stall = 1'b0; zero = 1'b0; beq = 1'b0; bne = 1'b0;
    jmp = 2'b00; btgt = '0; jrtgt = '0; jidx = '0; ovr_en = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick(); tick();
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    chk_cnt++; if (req !== 1'b0) $display("FAIL rst_req got %0b want 0", req); else pass_cnt++;
    chk_cnt++; if (addr !== 32'h0040_0000) $display("FAIL rst_addr got %h want 00400000", addr); else pass_cnt++;
    chk_cnt++; if (id_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", id_valid); else pass_cnt++;
    chk_cnt++; if (id_instr !== 32'h0) $display("FAIL rst_instr got %h want 0", id_instr); else pass_cnt++;
    chk_cnt++; if (id_pc4 !== 32'h0) $display("FAIL rst_pc4 got %h want 0", id_pc4); else pass_cnt++;
  endtask

  task automatic test_seq();
    logic [31:0] e;
    ready = 1'b1; reset = 1'b1;
    chk_cnt++; if (req !== 1'b0) $display("FAIL seq_boot_req got %0b want 0", req); else pass_cnt++;
    tick();
    chk_cnt++; if (req !== 1'b1 || addr !== 32'h0040_0000) $display("FAIL seq_first_req got %0b/%h want 1/00400000", req, addr); else pass_cnt++;
    tick();
    chk_cnt++; if (id_valid !== 1'b1 || id_instr !== m(32'h0040_0000)) $display("FAIL seq_latency got %0b/%h want 1/%h", id_valid, id_instr, m(32'h0040_0000)); else pass_cnt++;
    obs_q.delete(); exp_q.delete();
    e = 32'h0040_0004;
    for (int k = 0; k < 6; k++) begin
      chk_cnt++; if (id_valid !== 1'b1 || addr !== e || id_pc4 !== e) $display("FAIL seq_step%0d got %0b/%h/%h want 1/%h/%h", k, id_valid, addr, id_pc4, e, e); else pass_cnt++;
      exp_q.push_back({m(e - 32'd4), e});
      tick();
      e = e + 32'd4;
    end
    chk_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL seq_sb_count got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_ent = exp_q.pop_front(); o_ent = obs_q.pop_front();
      chk_cnt++; if (o_ent !== e_ent) $display("FAIL seq_sb got %h want %h", o_ent, e_ent); else pass_cnt++;
    end
  endtask

  task automatic test_branch();
    restart();
    exp_q.push_back({m(32'h0040_0000), 32'h0040_0004}); tick();
    beq = 1'b1; zero = 1'b1; btgt = 32'h0040_0100;
    exp_q.push_back({m(32'h0040_0004), 32'h0040_0008}); tick();
    beq = 1'b0; zero = 1'b0;
    chk_cnt++; if (addr !== 32'h0040_0100) $display("FAIL beq_addr got %h want 00400100", addr); else pass_cnt++;
    chk_cnt++; if (id_valid !== 1'b0) $display("FAIL beq_bubble got %0b want 0", id_valid); else pass_cnt++;
    tick();
    chk_cnt++; if (id_valid !== 1'b1 || id_pc4 !== 32'h0040_0104) $display("FAIL beq_target got %0b/%h want 1/00400104", id_valid, id_pc4); else pass_cnt++;
    bne = 1'b1; zero = 1'b1; btgt = 32'h0040_0200;
    exp_q.push_back({m(32'h0040_0100), 32'h0040_0104}); tick();
    bne = 1'b0; zero = 1'b0;
    chk_cnt++; if (addr !== 32'h0040_0108 || id_valid !== 1'b1) $display("FAIL bne_not_taken got %h/%0b want 00400108/1", addr, id_valid); else pass_cnt++;
    chk_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL branch_sb_count got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_ent = exp_q.pop_front(); o_ent = obs_q.pop_front();
      chk_cnt++; if (o_ent !== e_ent) $display("FAIL branch_sb got %h want %h", o_ent, e_ent); else pass_cnt++;
    end
  endtask

  task automatic test_jump();
    restart();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({m(32'h0040_0000 + 32'(4 * k)), 32'h0040_0004 + 32'(4 * k)}); tick();
    end
    chk_cnt++; if (id_pc4 !== 32'h0040_0010) $display("FAIL jal_setup got %h want 00400010", id_pc4); else pass_cnt++;
    jmp = 2'b01; jidx = 26'h010_0040; btgt = 32'h0040_0ABC;
    exp_q.push_back({m(32'h0040_000C), 32'h0040_0010}); tick();
    jmp = 2'b00;
    chk_cnt++; if (addr !== 32'h0040_0100 || id_valid !== 1'b0) $display("FAIL jal_addr got %h/%0b want 00400100/0", addr, id_valid); else pass_cnt++;
    tick();
    jmp = 2'b10; jrtgt = 32'h0040_0200; beq = 1'b1; zero = 1'b1; btgt = 32'h0040_0300;
    exp_q.push_back({m(32'h0040_0100), 32'h0040_0104}); tick();
    jmp = 2'b00; beq = 1'b0; zero = 1'b0;
    chk_cnt++; if (addr !== 32'h0040_0200 || id_valid !== 1'b0) $display("FAIL jr_addr got %h/%0b want 00400200/0", addr, id_valid); else pass_cnt++;
    tick();
    chk_cnt++; if (id_instr !== m(32'h0040_0200) || id_pc4 !== 32'h0040_0204) $display("FAIL jr_target got %h/%h want %h/00400204", id_instr, id_pc4, m(32'h0040_0200)); else pass_cnt++;
    jmp = 2'b11;
    exp_q.push_back({m(32'h0040_0200), 32'h0040_0204}); tick();
    jmp = 2'b00;
    chk_cnt++; if (addr !== 32'h0040_0208 || id_valid !== 1'b1) $display("FAIL jmp11_seq got %h/%0b want 00400208/1", addr, id_valid); else pass_cnt++;
    chk_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL jump_sb_count got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_ent = exp_q.pop_front(); o_ent = obs_q.pop_front();
      chk_cnt++; if (o_ent !== e_ent) $display("FAIL jump_sb got %h want %h", o_ent, e_ent); else pass_cnt++;
    end
  endtask

  task automatic test_stall_skid();
    restart();
    stall = 1'b1; ovr_en = 1'b1; ovr_val = 32'h8C08_0004;
    for (int k = 0; k < 3; k++) begin
      tick();
      ovr_en = 1'b0;
      chk_cnt++; if (req !== 1'b0 || id_instr !== m(32'h0040_0000) || id_pc4 !== 32'h0040_0004 || id_valid !== 1'b1)
        $display("FAIL skid_hold%0d got %0b/%h/%h/%0b want 0/%h/00400004/1", k, req, id_instr, id_pc4, id_valid, m(32'h0040_0000));
      else pass_cnt++;
    end
    stall = 1'b0;
    exp_q.push_back({m(32'h0040_0000), 32'h0040_0004}); tick();
    chk_cnt++; if (id_instr !== 32'h8C08_0004 || id_pc4 !== 32'h0040_0008) $display("FAIL skid_release got %h/%h want 8c080004/00400008", id_instr, id_pc4); else pass_cnt++;
    chk_cnt++; if (req !== 1'b1 || addr !== 32'h0040_0008) $display("FAIL skid_resume got %0b/%h want 1/00400008", req, addr); else pass_cnt++;
    exp_q.push_back({32'h8C08_0004, 32'h0040_0008}); tick();
    chk_cnt++; if (id_instr !== m(32'h0040_0008)) $display("FAIL skid_next got %h want %h", id_instr, m(32'h0040_0008)); else pass_cnt++;
    chk_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL skid_sb_count got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_ent = exp_q.pop_front(); o_ent = obs_q.pop_front();
      chk_cnt++; if (o_ent !== e_ent) $display("FAIL skid_sb got %h want %h", o_ent, e_ent); else pass_cnt++;
    end
  endtask

  task automatic test_wait_redirect();
    restart();
    ready = 1'b0; beq = 1'b1; zero = 1'b1; btgt = 32'h0040_0100;
    exp_q.push_back({m(32'h0040_0000), 32'h0040_0004}); tick();
    beq = 1'b0; zero = 1'b0;
    chk_cnt++; if (req !== 1'b1 || addr !== 32'h0040_0004 || id_valid !== 1'b0) $display("FAIL drop_hold got %0b/%h/%0b want 1/00400004/0", req, addr, id_valid); else pass_cnt++;
    tick();
    chk_cnt++; if (req !== 1'b1 || addr !== 32'h0040_0004) $display("FAIL drop_wait got %0b/%h want 1/00400004", req, addr); else pass_cnt++;
    ready = 1'b1; tick();
    chk_cnt++; if (addr !== 32'h0040_0100 || id_valid !== 1'b0) $display("FAIL drop_discard got %h/%0b want 00400100/0", addr, id_valid); else pass_cnt++;
    tick();
    chk_cnt++; if (id_valid !== 1'b1 || id_instr !== m(32'h0040_0100)) $display("FAIL drop_target got %0b/%h want 1/%h", id_valid, id_instr, m(32'h0040_0100)); else pass_cnt++;
    stall = 1'b1; beq = 1'b1; zero = 1'b1; btgt = 32'h0040_0300;
    tick();
    beq = 1'b0; zero = 1'b0;
    chk_cnt++; if (id_instr !== m(32'h0040_0100) || id_valid !== 1'b1 || req !== 1'b0) $display("FAIL stall_redirect got %h/%0b/%0b want %h/1/0", id_instr, id_valid, req, m(32'h0040_0100)); else pass_cnt++;
    stall = 1'b0;
    exp_q.push_back({m(32'h0040_0100), 32'h0040_0104}); tick();
    chk_cnt++; if (addr !== 32'h0040_0108 || id_pc4 !== 32'h0040_0108) $display("FAIL stall_redirect_ignored got %h/%h want 00400108/00400108", addr, id_pc4); else pass_cnt++;
    chk_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL wait_sb_count got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_ent = exp_q.pop_front(); o_ent = obs_q.pop_front();
      chk_cnt++; if (o_ent !== e_ent) $display("FAIL wait_sb got %h want %h", o_ent, e_ent); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    restart();
    ready = 1'b0;
    exp_q.push_back({m(32'h0040_0000), 32'h0040_0004}); tick();
    chk_cnt++; if (req !== 1'b1 || addr !== 32'h0040_0004) $display("FAIL mid_pending got %0b/%h want 1/00400004", req, addr); else pass_cnt++;
    reset = 1'b0; #1;
    chk_cnt++; if (req !== 1'b0 || id_valid !== 1'b0) $display("FAIL mid_async got %0b/%0b want 0/0", req, id_valid); else pass_cnt++;
    tick();
    reset = 1'b1; ready = 1'b1;
    chk_cnt++; if (req !== 1'b0) $display("FAIL mid_boot got %0b want 0", req); else pass_cnt++;
    tick();
    chk_cnt++; if (req !== 1'b1 || addr !== 32'h0040_0000) $display("FAIL mid_restart got %0b/%h want 1/00400000", req, addr); else pass_cnt++;
    tick();
    chk_cnt++; if (id_valid !== 1'b1 || id_pc4 !== 32'h0040_0004) $display("FAIL mid_first got %0b/%h want 1/00400004", id_valid, id_pc4); else pass_cnt++;
    chk_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL mid_sb_count got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_ent = exp_q.pop_front(); o_ent = obs_q.pop_front();
      chk_cnt++; if (o_ent !== e_ent) $display("FAIL mid_sb got %h want %h", o_ent, e_ent); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_branch();
    test_jump();
    test_stall_skid();
    test_wait_redirect();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
